cube_scan_ctrl: RTL and testbench

// - Layer-multiplex scan controller for the 8x8x8 LED cube. Takes whole frames from the frame generator
//   (64 columns x 8 layers) into a double buffer and drives the column shift registers (74HC595 chain)
//   one layer at a time. Drives the one-hot layer select with blanking around each latch.
// - Sits between the frame generator and the board pins. New frames take effect only at a frame boundary,
//   so a displayed frame never tears.

---
 rtl/cube_pkg.sv | 37 +++
 rtl/cube_sr_serializer.sv | 63 ++++++
 rtl/cube_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cube_scan_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared constants and types for the 8x8x8 LED cube scan path.
// Frame geometry, scan FSM states and small sizing helpers.
package cube_pkg;

  localparam int CUBE_NCOL    = 64;
  localparam int CUBE_NLAYER  = 8;
  localparam int CUBE_FRAME_W = 512;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    BLANK = 3'd2,
    LATCH = 3'd3,
    DWELL = 3'd4
  } scan_state_t;

  function automatic int cube_max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Width able to hold 0..n, never below 1 bit.
  function automatic int cube_cw(input int n);
    int w;
    w = $clog2(n + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/cube_sr_serializer.sv
// Shifts a 64-bit column word out MSB first to a 74HC595 chain.
// Ports: clk, clr_i, start_i, word_i -> ser_data_o, ser_clk_o, done_o.
module cube_sr_serializer
  import cube_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 clr_i,
  input  logic                 start_i,
  input  logic [CUBE_NCOL-1:0] word_i,
  output logic                 ser_data_o,
  output logic                 ser_clk_o,
  output logic                 done_o
);

  localparam int DW = cube_cw(CLK_DIV);

  logic          busy_q;
  logic          sclk_q;
  logic [5:0]    idx_q;
  logic [DW-1:0] div_q;
  logic          last_ph;

  assign last_ph = (div_q == DW'(CLK_DIV - 1));

  // Done is the last high cycle of bit 0.
  assign done_o = busy_q & sclk_q & last_ph
                & (idx_q == 6'd0);

  // The word is held stable by the owner for the
  // whole shift, so data only moves when idx_q does.
  assign ser_data_o = busy_q & word_i[idx_q];
  assign ser_clk_o  = sclk_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      idx_q  <= '0;
      div_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      sclk_q <= 1'b0;
      idx_q  <= 6'd63;
      div_q  <= '0;
    end else if (busy_q) begin
      if (last_ph) begin
        div_q <= '0;
        if (sclk_q) begin
          sclk_q <= 1'b0;
          if (idx_q == 6'd0) busy_q <= 1'b0;
          else idx_q <= idx_q - 6'd1;
        end else begin
          sclk_q <= 1'b1;
        end
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

endmodule

// File: rtl/cube_scan_ctrl.sv
// Layer-multiplex scan controller: double-buffered frames, 595 drive.
// Ports: clk, rst, enable, frame_* handshake, ser_*, layer_sel, frame_start.
module cube_scan_ctrl
  import cube_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int BLANK_CYCLES = 8,
  parameter int DWELL_CYCLES = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [CUBE_FRAME_W-1:0] frame_data,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  output logic                    ser_data,
  output logic                    ser_clk,
  output logic                    ser_latch,
  output logic                    ser_oe_n,
  output logic [CUBE_NLAYER-1:0]  layer_sel,
  output logic                    frame_start
);

  localparam int CMAX =
    cube_max3(DWELL_CYCLES, BLANK_CYCLES, CLK_DIV);
  localparam int CW = cube_cw(CMAX);

  scan_state_t             state_q, state_d;
  logic [2:0]              layer_q, layer_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    oe_n_q, oe_n_d;
  logic                    latch_q, latch_d;
  logic [CUBE_NLAYER-1:0]  sel_q, sel_d;
  logic                    fs_q, fs_d;
  logic [CUBE_FRAME_W-1:0] act_q, pend_q;
  logic                    pend_vld_q;
  logic                    swap, accept;
  logic                    sr_start, sr_clr, sr_done;
  logic [CUBE_NCOL-1:0]    word;

  assign frame_ready = ~pend_vld_q;
  assign accept      = frame_valid & ~pend_vld_q;
  assign sr_clr      = rst | ~enable;

  assign ser_latch   = latch_q;
  assign ser_oe_n    = oe_n_q;
  assign layer_sel   = sel_q;
  assign frame_start = fs_q;

  always_comb begin
    word = '0;
    for (int c = 0; c < CUBE_NCOL; c++)
      word[c] = act_q[c*CUBE_NLAYER + int'(layer_q)];
  end

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    cnt_d    = cnt_q;
    oe_n_d   = oe_n_q;
    latch_d  = 1'b0;
    sel_d    = sel_q;
    fs_d     = 1'b0;
    swap     = 1'b0;
    sr_start = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      layer_d = '0;
      cnt_d   = '0;
      oe_n_d  = 1'b1;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = SHIFT;
          layer_d  = '0;
          cnt_d    = '0;
          fs_d     = 1'b1;
          swap     = pend_vld_q;
          sr_start = 1'b1;
        end
        SHIFT: begin
          if (sr_done) begin
            state_d = BLANK;
            cnt_d   = '0;
            oe_n_d  = 1'b1;
          end
        end
        BLANK: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
            state_d = LATCH;
            cnt_d   = '0;
            latch_d = 1'b1;
            sel_d   = '0;
            sel_d[layer_q] = 1'b1;
          end
        end
        LATCH: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(CLK_DIV - 1)) begin
            state_d = DWELL;
            cnt_d   = '0;
            oe_n_d  = 1'b0;
          end else begin
            latch_d = 1'b1;
          end
        end
        DWELL: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
            state_d  = SHIFT;
            cnt_d    = '0;
            layer_d  = layer_q + 3'd1;
            sr_start = 1'b1;
            // Wrapping to layer 0 is the only tear-free swap point.
            if (layer_q == 3'd7) begin
              fs_d = 1'b1;
              swap = pend_vld_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      layer_q    <= '0;
      cnt_q      <= '0;
      oe_n_q     <= 1'b1;
      latch_q    <= 1'b0;
      sel_q      <= '0;
      fs_q       <= 1'b0;
      act_q      <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      cnt_q   <= cnt_d;
      oe_n_q  <= oe_n_d;
      latch_q <= latch_d;
      sel_q   <= sel_d;
      fs_q    <= fs_d;
      if (swap) begin
        act_q      <= pend_q;
        pend_vld_q <= 1'b0;
      end else if (accept) begin
        pend_vld_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) pend_q <= frame_data;
  end

  cube_sr_serializer #(
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .clk        (clk),
    .clr_i      (sr_clr),
    .start_i    (sr_start),
    .word_i     (word),
    .ser_data_o (ser_data),
    .ser_clk_o  (ser_clk),
    .done_o     (sr_done)
  );

endmodule

// File: tb/tb_cube_scan_ctrl.sv
// Bench for cube_scan_ctrl against a position-in-period scan model.
// Randomized frames; one task per scenario.
module tb_cube_scan_ctrl;
  import cube_pkg::*;

  localparam int CD = 1;
  localparam int BC = 2;
  localparam int DC = 4;
  localparam int SL = 128 * CD;
  localparam int LP = SL + BC + CD + DC;
  localparam int FP = 8 * LP;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         frame_valid = 1'b0;
  logic [511:0] frame_data = '0;
  logic         frame_ready, ser_data, ser_clk;
  logic         ser_latch, ser_oe_n, frame_start;
  logic [7:0]   layer_sel;

  int vecs = 0;
  int errs = 0;

  bit           m_run = 0;
  int           m_t = 0;
  bit           m_pv = 0;
  logic [511:0] m_act = '0;
  logic [511:0] m_pend = '0;

  logic       e_clk, e_data, e_latch, e_oe_n;
  logic       e_fs, e_ready, e_shift;
  logic [7:0] e_sel;
  int         e_layer;

  cube_scan_ctrl #(
    .CLK_DIV      (CD),
    .BLANK_CYCLES (BC),
    .DWELL_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .ser_data    (ser_data),
    .ser_clk     (ser_clk),
    .ser_latch   (ser_latch),
    .ser_oe_n    (ser_oe_n),
    .layer_sel   (layer_sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] rnd_frame();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  // Advance one edge, update the model from the inputs seen at
  // that edge, then settle 1 time unit past the edge.
  task automatic tick();
    bit acc;
    int pp;
    int pl;
    bit first;
    @(posedge clk);
    acc = frame_valid && !m_pv;
    if (rst) begin
      m_run = 0;
      m_pv  = 0;
      m_act = '0;
    end else begin
      if (!enable) begin
        m_run = 0;
      end else begin
        if (m_run) m_t++;
        else begin
          m_run = 1;
          m_t   = 0;
        end
        if ((m_t % FP) == 0 && m_pv) begin
          m_act = m_pend;
          m_pv  = 0;
        end
      end
      if (acc) begin
        m_pend = frame_data;
        m_pv   = 1;
      end
    end
    e_ready = !m_pv;
    e_clk   = 0;
    e_data  = 0;
    e_latch = 0;
    e_oe_n  = 1;
    e_fs    = 0;
    e_sel   = '0;
    e_shift = 0;
    e_layer = 0;
    if (m_run) begin
      pp      = m_t % LP;
      e_layer = (m_t / LP) % 8;
      pl      = (e_layer + 7) % 8;
      first   = (m_t < LP);
      e_fs    = ((m_t % FP) == 0);
      if (pp < SL + BC) begin
        if (!first) e_sel = 8'(1) << pl;
      end else begin
        e_sel = 8'(1) << e_layer;
      end
      if (pp < SL) begin
        e_shift = 1;
        e_clk   = (pp % (2*CD)) >= CD;
        e_data  = m_act[(63 - pp/(2*CD))*8 + e_layer];
        e_oe_n  = first;
      end else if (pp < SL + BC) begin
        e_oe_n = 1;
      end else if (pp < SL + BC + CD) begin
        e_oe_n  = 1;
        e_latch = 1;
      end else begin
        e_oe_n = 0;
      end
    end
    #1;
  endtask

  task automatic advance(input int pos);
    int n;
    n = 0;
    while (!m_run || (m_t % FP) != pos) begin
      tick();
      n++;
      if (n > 2*FP) begin
        vecs++;
        errs++;
        $display("FAIL advance: pos %0d not reached, t=%0d", pos, m_t);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    enable = 1'b1;
    repeat (3) begin
      tick();
      vecs++; if (ser_oe_n !== 1'b1) begin errs++; $display("FAIL rst_oe_n: got %b want 1", ser_oe_n); end
      vecs++; if (layer_sel !== 8'h00) begin errs++; $display("FAIL rst_sel: got %h want 00", layer_sel); end
      vecs++; if (frame_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", frame_ready); end
      vecs++; if ({ser_clk, ser_latch, ser_data, frame_start} !== 4'b0) begin errs++; $display("FAIL rst_misc: got %b want 0000", {ser_clk, ser_latch, ser_data, frame_start}); end
    end
    rst = 1'b0;
    tick();
    vecs++; if (frame_start !== 1'b1) begin errs++; $display("FAIL rst_fs: got %b want 1", frame_start); end
    vecs++; if (frame_start !== e_fs) begin errs++; $display("FAIL rst_fs_model: got %b want %b", frame_start, e_fs); end
  endtask

  task automatic test_single_bit();
    logic [511:0] f;
    logic prev_clk;
    int rises;
    int ones;
    logic first_bit;
    f = '0;
    f[63*8] = 1'b1;
    frame_data  = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    vecs++; if (frame_ready !== 1'b0) begin errs++; $display("FAIL sb_ready: got %b want 0", frame_ready); end
    advance(0);
    prev_clk  = 1'b0;
    rises     = 0;
    ones      = 0;
    first_bit = 1'bx;
    for (int i = 0; i < FP; i++) begin
      if (e_shift) begin
        vecs++; if (ser_clk !== e_clk) begin errs++; $display("FAIL sb_clk t=%0d: got %b want %b", m_t, ser_clk, e_clk); end
        vecs++; if (ser_data !== e_data) begin errs++; $display("FAIL sb_data t=%0d: got %b want %b", m_t, ser_data, e_data); end
      end
      if (ser_clk === 1'b1 && prev_clk === 1'b0) begin
        if (rises == 0) first_bit = ser_data;
        if (ser_data === 1'b1) ones++;
        rises++;
      end
      prev_clk = ser_clk;
      if (e_latch) begin
        vecs++; if (rises !== 64) begin errs++; $display("FAIL sb_rises L%0d: got %0d want 64", e_layer, rises); end
        if (e_layer == 0) begin
          vecs++; if (first_bit !== 1'b1) begin errs++; $display("FAIL sb_first L0: got %b want 1", first_bit); end
          vecs++; if (ones !== 1) begin errs++; $display("FAIL sb_ones L0: got %0d want 1", ones); end
        end else begin
          vecs++; if (ones !== 0) begin errs++; $display("FAIL sb_ones L%0d: got %0d want 0", e_layer, ones); end
        end
        rises = 0;
        ones  = 0;
      end
      tick();
    end
  endtask

  task automatic test_layer_timing();
    int hi_run;
    int lat_run;
    int nlat;
    int last_fs;
    logic prev_lat;
    advance(0);
    hi_run   = 0;
    lat_run  = 0;
    nlat     = 0;
    last_fs  = -1;
    prev_lat = 1'b0;
    for (int i = 0; i < FP + LP; i++) begin
      vecs++; if (ser_latch !== e_latch) begin errs++; $display("FAIL lt_latch t=%0d: got %b want %b", m_t, ser_latch, e_latch); end
      vecs++; if (layer_sel !== e_sel) begin errs++; $display("FAIL lt_sel t=%0d: got %h want %h", m_t, layer_sel, e_sel); end
      vecs++; if (ser_oe_n !== e_oe_n) begin errs++; $display("FAIL lt_oe_n t=%0d: got %b want %b", m_t, ser_oe_n, e_oe_n); end
      vecs++; if (frame_start !== e_fs) begin errs++; $display("FAIL lt_fs t=%0d: got %b want %b", m_t, frame_start, e_fs); end
      if (ser_latch === 1'b1 && prev_lat === 1'b0) begin
        vecs++; if (hi_run !== BC) begin errs++; $display("FAIL lt_blank: got %0d want %0d", hi_run, BC); end
        vecs++; if (layer_sel !== (8'(1) << (nlat % 8))) begin errs++; $display("FAIL lt_order #%0d: got %h want %h", nlat, layer_sel, 8'(1) << (nlat % 8)); end
        nlat++;
      end
      if (ser_latch === 1'b0 && prev_lat === 1'b1) begin
        vecs++; if (lat_run !== CD) begin errs++; $display("FAIL lt_latlen: got %0d want %0d", lat_run, CD); end
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          vecs++; if (i - last_fs !== FP) begin errs++; $display("FAIL lt_fsper: got %0d want %0d", i - last_fs, FP); end
        end
        last_fs = i;
      end
      hi_run   = (ser_oe_n === 1'b1) ? hi_run + 1 : 0;
      lat_run  = (ser_latch === 1'b1) ? lat_run + 1 : 0;
      prev_lat = ser_latch;
      tick();
    end
    vecs++; if (nlat !== 9) begin errs++; $display("FAIL lt_nlat: got %0d want 9", nlat); end
  endtask

  task automatic test_handshake();
    logic [511:0] fa, fb;
    int rdy_cnt;
    logic rdy_fs;
    fa = rnd_frame();
    fb = rnd_frame();
    advance(500);
    frame_data  = fa;
    frame_valid = 1'b1;
    tick();
    frame_data = fb;
    rdy_cnt = 0;
    rdy_fs  = 1'b0;
    for (int i = 0; i < FP; i++) begin
      vecs++; if (frame_ready !== e_ready) begin errs++; $display("FAIL hs_ready t=%0d: got %b want %b", m_t, frame_ready, e_ready); end
      if (e_shift) begin
        vecs++; if (ser_data !== e_data) begin errs++; $display("FAIL hs_data t=%0d: got %b want %b", m_t, ser_data, e_data); end
      end
      if (frame_ready === 1'b1) begin
        rdy_cnt++;
        rdy_fs = frame_start;
      end
      tick();
    end
    frame_valid = 1'b0;
    vecs++; if (rdy_cnt !== 1) begin errs++; $display("FAIL hs_rdycnt: got %0d want 1", rdy_cnt); end
    vecs++; if (rdy_fs !== 1'b1) begin errs++; $display("FAIL hs_rdy_at_fs: got %b want 1", rdy_fs); end
    advance(0);
    for (int i = 0; i < FP; i++) begin
      if (e_shift) begin
        vecs++; if (ser_data !== e_data) begin errs++; $display("FAIL hs_b_data t=%0d: got %b want %b", m_t, ser_data, e_data); end
      end
      tick();
    end
  endtask

  task automatic test_enable_drop();
    advance(3*LP + 60);
    enable = 1'b0;
    repeat (5) begin
      tick();
      vecs++; if (ser_oe_n !== 1'b1) begin errs++; $display("FAIL en_oe_n: got %b want 1", ser_oe_n); end
      vecs++; if (layer_sel !== 8'h00) begin errs++; $display("FAIL en_sel: got %h want 00", layer_sel); end
      vecs++; if ({ser_clk, ser_latch, frame_start} !== 3'b0) begin errs++; $display("FAIL en_misc: got %b want 000", {ser_clk, ser_latch, frame_start}); end
    end
    enable = 1'b1;
    tick();
    vecs++; if (frame_start !== 1'b1) begin errs++; $display("FAIL en_fs: got %b want 1", frame_start); end
    for (int i = 0; i < FP; i++) begin
      if (e_shift) begin
        vecs++; if (ser_data !== e_data) begin errs++; $display("FAIL en_data t=%0d: got %b want %b", m_t, ser_data, e_data); end
      end
      vecs++; if (layer_sel !== e_sel) begin errs++; $display("FAIL en_lsel t=%0d: got %h want %h", m_t, layer_sel, e_sel); end
      vecs++; if (ser_oe_n !== e_oe_n) begin errs++; $display("FAIL en_loe t=%0d: got %b want %b", m_t, ser_oe_n, e_oe_n); end
      tick();
    end
  endtask

  task automatic test_rst_dwell();
    logic [511:0] fc;
    fc = rnd_frame();
    fc[0] = 1'b1;
    advance(0);
    frame_data  = fc;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    vecs++; if (frame_ready !== 1'b0) begin errs++; $display("FAIL rd_pend: got %b want 0", frame_ready); end
    advance(2*LP + SL + BC + CD + 1);
    rst = 1'b1;
    tick();
    vecs++; if (frame_ready !== 1'b1) begin errs++; $display("FAIL rd_ready: got %b want 1", frame_ready); end
    vecs++; if (ser_oe_n !== 1'b1) begin errs++; $display("FAIL rd_oe_n: got %b want 1", ser_oe_n); end
    vecs++; if (layer_sel !== 8'h00) begin errs++; $display("FAIL rd_sel: got %h want 00", layer_sel); end
    rst = 1'b0;
    tick();
    vecs++; if (frame_start !== 1'b1) begin errs++; $display("FAIL rd_fs: got %b want 1", frame_start); end
    for (int i = 0; i < 2*FP; i++) begin
      if (e_shift) begin
        vecs++; if (ser_data !== 1'b0) begin errs++; $display("FAIL rd_data t=%0d: got %b want 0", m_t, ser_data); end
      end
      vecs++; if (frame_ready !== 1'b1) begin errs++; $display("FAIL rd_ready2 t=%0d: got %b want 1", m_t, frame_ready); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_layer_timing();
    test_handshake();
    test_enable_drop();
    test_rst_dwell();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
